// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Constants shared by the data-segment memory of the single-cycle RISC-V
//   core: machine word width, the data segment base address and the default
//   memory depth.
//   No ports (package).
package riscv_mem_pkg;

  localparam int unsigned XLEN                = 32;
  localparam logic [31:0] DATA_BASE           = 32'h1001_0000;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

  // Size in bytes of a region of the given number of 32-bit words.
  function automatic logic [31:0] span_bytes(input int unsigned depth_words);
    return 32'(depth_words * 4);
  endfunction

endpackage : riscv_mem_pkg

// File: rtl/mem_addr_decode.sv
// mem_addr_decode
//   Maps a byte address onto a word index of a region of DEPTH_WORDS 32-bit
//   words starting at BASE_ADDR, and flags whether the address hits it.
//   Ports:
//     addr  in  32  byte address
//     hit   out 1   address lies inside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4)
//     index out AW  word index inside the region (only meaningful when hit)
module mem_addr_decode
  import riscv_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DATA_BASE,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic [XLEN-1:0] addr,
  output logic            hit,
  output logic [AW-1:0]   index
);

  localparam logic [31:0] SPAN = span_bytes(DEPTH_WORDS);

  logic [31:0] offset;

  // Unsigned 32-bit subtraction: addresses below the base wrap to a huge
  // offset, so a single upper-bound compare covers both sides of the region.
  // The two low address bits are dropped so misaligned accesses land on the
  // containing word.
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (offset < SPAN);
    index  = offset[AW+1:2];
  end

endmodule : mem_addr_decode

// File: rtl/data_mem.sv
// data_mem
//   Word-organised data memory for the single-cycle RISC-V core, mapped at
//   BASE_ADDR. Writes happen on the rising clock edge; reads are
//   combinational so a load completes in the cycle its address is applied.
//   Ports:
//     clk      in  1   system clock, rising edge active
//     rst      in  1   synchronous active-high reset; clears every word and
//                      wins over a simultaneous write
//     Addr     in  32  byte address (Addr[1:0] ignored)
//     Data_in  in  32  store data
//     Wr_en    in  1   1 = store Data_in to the addressed word this cycle
//     Data_out out 32  word at Addr, or 0 when Addr is outside the region
module data_mem
  import riscv_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DATA_BASE,
  parameter int unsigned DEPTH_WORDS    = DEFAULT_DEPTH_WORDS,
  // Clearing the whole array on reset prevents RAM inference; a build that
  // wants distributed RAM sets this to 0 (reset then only blocks the write).
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] Data_in,
  input  logic            Wr_en,
  output logic [XLEN-1:0] Data_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic            hit;
  logic [AW-1:0]   index;

  mem_addr_decode #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_decode (
    .addr  (Addr),
    .hit   (hit),
    .index (index)
  );

  // Out-of-range stores are dropped rather than aliased onto the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
          mem[i] <= '0;
        end
      end
    end else if (Wr_en && hit) begin
      mem[index] <= Data_in;
    end
  end

  // No write-through bypass: before the edge the old word is visible.
  always_comb begin
    Data_out = '0;
    if (hit) begin
      Data_out = mem[index];
    end
  end

endmodule : data_mem

// File: tb/tb_data_mem.sv
// tb_data_mem
//   Directed self-checking bench for data_mem at its default parameters.
module tb_data_mem;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] END  = 32'h1001_1000;

  logic        clk;
  logic        rst;
  logic [31:0] Addr;
  logic [31:0] Data_in;
  logic        Wr_en;
  logic [31:0] Data_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  data_mem dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .Data_in  (Data_in),
    .Wr_en    (Wr_en),
    .Data_out (Data_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    Wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr    = a;
    Data_in = d;
    Wr_en   = 1'b1;
    @(posedge clk);
    #1;
    Wr_en = 1'b0;
  endtask

  task automatic read_addr(input logic [31:0] a);
    Wr_en = 1'b0;
    Addr  = a;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    read_addr(BASE);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_base: got %h want %h", Data_out, 32'h0);
    end
    read_addr(END - 4);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_last: got %h want %h", Data_out, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    do_write(BASE,          32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    do_write(BASE + 32'd4,  32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    a = BASE;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      read_addr(a);
      checks++;
      if (Data_out !== exp_v) begin
        errors++;
        $display("FAIL b2b_read @%h: got %h want %h", a, Data_out, exp_v);
      end
      a = a + 32'd4;
    end
  endtask

  task automatic test_out_of_range();
    read_addr(32'h0000_0000);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL oor_read_zero: got %h want %h", Data_out, 32'h0);
    end
    do_write(32'h0000_0000, 32'hFFFF_FFFF);
    read_addr(BASE);
    checks++;
    if (Data_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL oor_write_zero_alias: got %h want %h", Data_out, 32'hDEAD_BEEF);
    end
    do_write(END, 32'h7777_7777);
    read_addr(END);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL oor_end_read: got %h want %h", Data_out, 32'h0);
    end
    read_addr(BASE);
    checks++;
    if (Data_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL oor_end_alias: got %h want %h", Data_out, 32'hDEAD_BEEF);
    end
    do_write(BASE - 32'd4, 32'h3333_3333);
    read_addr(BASE - 32'd4);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL oor_below_read: got %h want %h", Data_out, 32'h0);
    end
    read_addr(END - 4);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL oor_below_alias: got %h want %h", Data_out, 32'h0);
    end
  endtask

  task automatic test_misaligned();
    do_write(BASE + 32'd9, 32'hA5A5_A5A5);
    read_addr(BASE + 32'd8);
    checks++;
    if (Data_out !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL misaligned_word: got %h want %h", Data_out, 32'hA5A5_A5A5);
    end
    read_addr(BASE + 32'd11);
    checks++;
    if (Data_out !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL misaligned_byte3: got %h want %h", Data_out, 32'hA5A5_A5A5);
    end
    read_addr(BASE + 32'd12);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_next: got %h want %h", Data_out, 32'h0);
    end
  endtask

  task automatic test_last_word();
    do_write(END - 32'd4, 32'hCAFE_F00D);
    read_addr(END - 32'd4);
    checks++;
    if (Data_out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL last_word: got %h want %h", Data_out, 32'hCAFE_F00D);
    end
    read_addr(END);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL past_end: got %h want %h", Data_out, 32'h0);
    end
  endtask

  task automatic test_hold();
    repeat (5) @(posedge clk);
    #1;
    read_addr(BASE + 32'd4);
    checks++;
    if (Data_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hold: got %h want %h", Data_out, 32'h1234_5678);
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    Addr    = BASE;
    Data_in = 32'h1111_2222;
    Wr_en   = 1'b1;
    #1;
    checks++;
    if (Data_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL no_bypass_before: got %h want %h", Data_out, 32'hDEAD_BEEF);
    end
    @(posedge clk);
    #1;
    Wr_en = 1'b0;
    checks++;
    if (Data_out !== 32'h1111_2222) begin
      errors++;
      $display("FAIL no_bypass_after: got %h want %h", Data_out, 32'h1111_2222);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    Addr    = BASE;
    Data_in = 32'h5555_5555;
    Wr_en   = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    Wr_en = 1'b0;
    read_addr(BASE);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio_base: got %h want %h", Data_out, 32'h0);
    end
    read_addr(BASE + 32'd4);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio_base4: got %h want %h", Data_out, 32'h0);
    end
    read_addr(END - 32'd4);
    checks++;
    if (Data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio_last: got %h want %h", Data_out, 32'h0);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst     = 1'b0;
    Addr    = '0;
    Data_in = '0;
    Wr_en   = 1'b0;
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_misaligned();
    test_last_word();
    test_hold();
    test_no_bypass();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_mem

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised RISC-V data memory for the single-cycle core, mapped at the data segment base 0x1001_0000.
- Writes are synchronous on the clock edge; reads are combinational so a load completes in the same cycle.
- Sits between the ALU address output and the register-file writeback mux.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- AW, $clog2(DEPTH_WORDS), derived word-index width; not user-overridable.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- Addr  input  32  byte address.
- Data_in  input  32  write data.
- Wr_en  input  1  write enable, 1 = store this cycle.
- Data_out  output  32  read data, combinational.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Storage: array of DEPTH_WORDS x 32-bit words.
- Hit decode:
  - Offset = Addr - BASE_ADDR, computed in 32-bit unsigned arithmetic; wrap makes addresses below base huge.
  - hit = (offset < DEPTH_WORDS*4).
  - Word index = offset[AW+1:2].
  - Addr[1:0] is ignored; misaligned accesses act on the containing word.
- Read:
  - Data_out = mem[index] when hit, else 32'h0000_0000.
  - Purely combinational; no registered output, zero-cycle latency.
  - Data_out follows Addr and memory contents within the same cycle.
- Write:
  - On posedge clk, when Wr_en=1, hit=1 and rst=0: mem[index] <= Data_in.
  - Data_out for that address shows the new value immediately after the edge.
  - Before the edge, a read of the same address returns the old value; there is no write-through bypass.
- Out-of-range write (hit=0): ignored; no array word changes and nothing aliases.
- Reset:
  - On posedge clk with rst=1, every word clears to 0.
  - rst has priority over a simultaneous Wr_en.
  - After the reset edge, Data_out = 0 for any address.
  - Reset asserted in the middle of a write sequence discards that cycle's write.
- Wr_en=0: the array holds its contents indefinitely.
- Initial contents:
  - Simulation: all zero.
  - The array is inferable as distributed RAM when reset clearing is disabled by synthesis (see Decomposition).
- Boundaries:
  - Addr = BASE_ADDR + DEPTH_WORDS*4 - 4 is the last valid word.
  - Addr = BASE_ADDR + DEPTH_WORDS*4 misses.
  - Addr = BASE_ADDR - 4 misses; the wrap produces a huge offset.

Decomposition:
- Shared package riscv_mem_pkg:
  - DATA_BASE = 32'h1001_0000.
  - XLEN = 32.
  - default depth constant.
- data_mem imports these constants.
- Sub-module mem_addr_decode (BASE_ADDR, DEPTH_WORDS) produces hit and index; the top holds the array and the read mux.
- No other sub-modules.

Test Plan:
- Reset, then read: rst=1 for one edge, then Addr=0x1001_0000 -> Data_out=0x0000_0000.
- Back-to-back writes then reads:
  - Write 0xDEAD_BEEF @0x1001_0000, then 0x1234_5678 @0x1001_0004 on consecutive edges.
  - With Wr_en=0, read 0x1001_0000 -> 0xDEAD_BEEF, read 0x1001_0004 -> 0x1234_5678, each in the same cycle Addr is applied.
- Out of range:
  - Addr=0x0000_0000 -> Data_out=0.
  - Write 0xFFFF_FFFF @0x0000_0000, then read 0x1001_0000 -> unchanged.
  - Also write and read Addr=BASE_ADDR+DEPTH_WORDS*4 -> ignored; reads 0.
- Misaligned: write 0xA5A5_A5A5 @0x1001_0009 -> read 0x1001_0008 returns 0xA5A5_A5A5.
- Last word: write 0xCAFE_F00D @0x1001_0FFC (default depth) -> reads back 0xCAFE_F00D; 0x1001_1000 reads 0.
- Reset priority: rst=1 and Wr_en=1 with 0x5555_5555 @0x1001_0000 on the same edge -> after the edge 0x1001_0000 and 0x1001_0004 both read 0.
